// File: rtl/fsm_path_driver.sv
`default_nettype none
// ============================================================================
//  Module   : fsm_path_driver
//  Purpose  : Initiator for the single-bit `a` input of the 5-state control
//             FSM (states 0..4). It accepts a target-state command and drives
//             `a` along the shortest path until the FSM reaches the target.
//             It then reports completion, or an error for an invalid target
//             or a timeout. A shadow copy of the FSM state is kept and checked
//             against the FSM's own state output.
//  Ports    : clk, reset_l          - clock (rising edge), async active-low reset
//             cmd_valid/cmd_target  - command request and requested target state
//             cmd_ready             - command can be accepted (driver idle)
//             a                     - registered drive into the FSM `a` input
//             state_obs             - FSM state output
//             done_valid/err/steps  - completion pulse, error flag, step count
//             mismatch              - sticky: state_obs disagreed with shadow
//  Revision : 1.0  initial release
// ============================================================================
module fsm_path_driver #(
    parameter int MAX_STEPS = 6
) (
    input  logic       clk,
    input  logic       reset_l,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_target,
    output logic       cmd_ready,
    output logic       a,
    input  logic [2:0] state_obs,
    output logic       done_valid,
    output logic       done_err,
    output logic [2:0] done_steps,
    output logic       mismatch
);

    localparam int CNT_W = 8;

    typedef enum logic [0:0] {
        CTL_IDLE  = 1'b0,
        CTL_DRIVE = 1'b1
    } ctl_t;

    ctl_t             r_ctl;
    logic [2:0]       r_shadow;
    logic [2:0]       r_target;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]       w_shadow_next;
    logic [2:0]       w_cnt_sat;

    // FSM transition function, mirrored locally as the shadow model.
    function automatic logic [2:0] f_next_shadow(input logic [2:0] s, input logic in_a);
        case (s)
            3'd0:    f_next_shadow = in_a ? 3'd4 : 3'd1;
            3'd1:    f_next_shadow = in_a ? 3'd3 : 3'd2;
            3'd2:    f_next_shadow = in_a ? 3'd3 : 3'd2;
            3'd3:    f_next_shadow = 3'd0;
            3'd4:    f_next_shadow = in_a ? 3'd0 : 3'd4;
            default: f_next_shadow = 3'd0;
        endcase
    endfunction

    // First step of the shortest path from s towards t.
    function automatic logic f_next_a(input logic [2:0] s, input logic [2:0] t);
        if (s == t) begin
            f_next_a = 1'b0;
        end else begin
            case (s)
                3'd0:    f_next_a = (t == 3'd4);
                3'd1:    f_next_a = (t != 3'd2);
                3'd2:    f_next_a = 1'b1;
                3'd3:    f_next_a = 1'b0;
                3'd4:    f_next_a = 1'b1;
                default: f_next_a = 1'b0;
            endcase
        end
    endfunction

    // The state the FSM will show after this edge, given the `a` it sees now.
    assign w_shadow_next = f_next_shadow(r_shadow, a);
    assign w_cnt_sat     = (r_cnt > CNT_W'(7)) ? 3'd7 : r_cnt[2:0];
    assign cmd_ready     = (r_ctl == CTL_IDLE);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_ctl      <= CTL_IDLE;
            r_shadow   <= 3'd0;
            r_target   <= 3'd0;
            r_cnt      <= '0;
            a          <= 1'b0;
            done_valid <= 1'b0;
            done_err   <= 1'b0;
            done_steps <= 3'd0;
            mismatch   <= 1'b0;
        end else begin
            r_shadow   <= w_shadow_next;
            done_valid <= 1'b0;
            if (state_obs != r_shadow) begin
                mismatch <= 1'b1;
            end

            case (r_ctl)
                CTL_IDLE: begin
                    a <= 1'b0;
                    if (cmd_valid) begin
                        if (cmd_target > 3'd4) begin
                            done_valid <= 1'b1;
                            done_err   <= 1'b1;
                            done_steps <= 3'd0;
                        end else begin
                            r_target <= cmd_target;
                            r_cnt    <= CNT_W'(1);
                            // Free-running FSM may land on the target by itself.
                            if (w_shadow_next == cmd_target) begin
                                done_valid <= 1'b1;
                                done_err   <= 1'b0;
                                done_steps <= 3'd0;
                            end else begin
                                r_ctl <= CTL_DRIVE;
                                a     <= f_next_a(w_shadow_next, cmd_target);
                            end
                        end
                    end
                end

                CTL_DRIVE: begin
                    if (w_shadow_next == r_target) begin
                        done_valid <= 1'b1;
                        done_err   <= 1'b0;
                        done_steps <= w_cnt_sat;
                        r_ctl      <= CTL_IDLE;
                        a          <= 1'b0;
                    end else if (r_cnt >= CNT_W'(MAX_STEPS)) begin
                        done_valid <= 1'b1;
                        done_err   <= 1'b1;
                        done_steps <= w_cnt_sat;
                        r_ctl      <= CTL_IDLE;
                        a          <= 1'b0;
                    end else begin
                        a     <= f_next_a(w_shadow_next, r_target);
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_ctl <= CTL_IDLE;
                    a     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fsm_path_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fsm_path_driver
//  Purpose  : Directed testbench for fsm_path_driver. Two instances share the
//             clock and reset: dut1 with the default MAX_STEPS and dut2 with
//             MAX_STEPS=2. Each drives its own behavioural copy of the control
//             FSM. dut2's observed state can be corrupted on demand.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fsm_path_driver;

    logic       clk;
    logic       reset_l;

    logic       cmd_valid1, cmd_valid2;
    logic [2:0] cmd_target1, cmd_target2;
    logic       cmd_ready1, cmd_ready2;
    logic       a1, a2;
    logic [2:0] state_obs1, state_obs2;
    logic       done_valid1, done_valid2;
    logic       done_err1, done_err2;
    logic [2:0] done_steps1, done_steps2;
    logic       mismatch1, mismatch2;

    logic [2:0] fsm1, fsm2;
    logic       corrupt2;

    int n_pass;
    int n_total;

    fsm_path_driver u_dut1 (
        .clk(clk), .reset_l(reset_l),
        .cmd_valid(cmd_valid1), .cmd_target(cmd_target1), .cmd_ready(cmd_ready1),
        .a(a1), .state_obs(state_obs1),
        .done_valid(done_valid1), .done_err(done_err1), .done_steps(done_steps1),
        .mismatch(mismatch1)
    );

    fsm_path_driver #(.MAX_STEPS(2)) u_dut2 (
        .clk(clk), .reset_l(reset_l),
        .cmd_valid(cmd_valid2), .cmd_target(cmd_target2), .cmd_ready(cmd_ready2),
        .a(a2), .state_obs(state_obs2),
        .done_valid(done_valid2), .done_err(done_err2), .done_steps(done_steps2),
        .mismatch(mismatch2)
    );

    // Behavioural control FSM that each driver steers.
    function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic in_a);
        case (s)
            3'd0:    return in_a ? 3'd4 : 3'd1;
            3'd1:    return in_a ? 3'd3 : 3'd2;
            3'd2:    return in_a ? 3'd3 : 3'd2;
            3'd3:    return 3'd0;
            3'd4:    return in_a ? 3'd0 : 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            fsm1 <= 3'd0;
            fsm2 <= 3'd0;
        end else begin
            fsm1 <= fsm_next(fsm1, a1);
            fsm2 <= fsm_next(fsm2, a2);
        end
    end

    assign state_obs1 = fsm1;
    assign state_obs2 = fsm2 ^ {2'b00, corrupt2};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [2:0] exp_s [4];
        exp_s = '{3'd0, 3'd1, 3'd2, 3'd2};
        reset_l = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({a1, cmd_ready1, done_valid1, done_err1, done_steps1, mismatch1, state_obs1} !== 10'b0_1_0_0_000_0_000)
            $display("FAIL reset_dut1 got a=%b rdy=%b dv=%b err=%b steps=%0d mm=%b s=%0d want 0 1 0 0 0 0 0",
                     a1, cmd_ready1, done_valid1, done_err1, done_steps1, mismatch1, state_obs1);
        else n_pass++;
        n_total++;
        if ({a2, cmd_ready2, done_valid2, done_err2, done_steps2, mismatch2} !== 8'b0_1_0_0_000_0)
            $display("FAIL reset_dut2 got a=%b rdy=%b dv=%b err=%b steps=%0d mm=%b want 0 1 0 0 0 0",
                     a2, cmd_ready2, done_valid2, done_err2, done_steps2, mismatch2);
        else n_pass++;
        reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({a1, cmd_ready1, mismatch1, done_valid1, state_obs1} !== {4'b0100, exp_s[i]})
                $display("FAIL idle_walk cyc=%0d got a=%b rdy=%b mm=%b dv=%b s=%0d want a=0 rdy=1 mm=0 dv=0 s=%0d",
                         i, a1, cmd_ready1, mismatch1, done_valid1, state_obs1, exp_s[i]);
            else n_pass++;
            @(negedge clk);
        end
        n_total++;
        if ({state_obs2, mismatch2} !== {3'd2, 1'b0})
            $display("FAIL idle_dut2 got s=%0d mm=%b want s=2 mm=0", state_obs2, mismatch2);
        else n_pass++;
    endtask

    // From state 2 drive to 4: a = 1,0,1; FSM 3,0,4; done after 3 steps.
    task automatic test_path_2_to_4();
        logic [5:0] exp_v [4];   // {a, state, done_valid, cmd_ready}
        exp_v = '{{1'b1, 3'd2, 2'b00}, {1'b0, 3'd3, 2'b00}, {1'b1, 3'd0, 2'b00}, {1'b0, 3'd4, 2'b11}};
        cmd_valid1 = 1'b1; cmd_target1 = 3'd4;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if ({a1, state_obs1, done_valid1, cmd_ready1} !== exp_v[k])
                $display("FAIL path_2_to_4 cyc=%0d got {a,s,dv,rdy}=%b want %b", k,
                         {a1, state_obs1, done_valid1, cmd_ready1}, exp_v[k]);
            else n_pass++;
            if (k < 3) @(negedge clk);
        end
        n_total++;
        if ({done_err1, done_steps1} !== {1'b0, 3'd3})
            $display("FAIL path_2_to_4_steps got err=%b steps=%0d want err=0 steps=3", done_err1, done_steps1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done_valid1, a1, state_obs1} !== {2'b00, 3'd4})
            $display("FAIL path_2_to_4_after got dv=%b a=%b s=%0d want dv=0 a=0 s=4", done_valid1, a1, state_obs1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (state_obs1 !== 3'd4)
            $display("FAIL hold_at_4 got s=%0d want 4", state_obs1);
        else n_pass++;
    endtask

    // 4->1 in two steps, then immediately target 1 again from state 1.
    task automatic test_back_to_back();
        logic [5:0] exp_v [7];
        exp_v = '{{1'b1, 3'd4, 2'b00}, {1'b0, 3'd0, 2'b00}, {1'b0, 3'd1, 2'b11},
                  {1'b1, 3'd2, 2'b00}, {1'b0, 3'd3, 2'b00}, {1'b0, 3'd0, 2'b00}, {1'b0, 3'd1, 2'b11}};
        cmd_valid1 = 1'b1; cmd_target1 = 3'd1;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            n_total++;
            if ({a1, state_obs1, done_valid1, cmd_ready1} !== exp_v[k])
                $display("FAIL back_to_back cyc=%0d got {a,s,dv,rdy}=%b want %b", k,
                         {a1, state_obs1, done_valid1, cmd_ready1}, exp_v[k]);
            else n_pass++;
            if (k == 2) begin
                n_total++;
                if ({done_err1, done_steps1} !== {1'b0, 3'd2})
                    $display("FAIL b2b_first_steps got err=%b steps=%0d want err=0 steps=2", done_err1, done_steps1);
                else n_pass++;
                cmd_valid1 = 1'b1; cmd_target1 = 3'd1;
                @(negedge clk);
                cmd_valid1 = 1'b0;
            end else if (k < 6) begin
                @(negedge clk);
            end
        end
        n_total++;
        if ({done_err1, done_steps1} !== {1'b0, 3'd3})
            $display("FAIL b2b_second_steps got err=%b steps=%0d want err=0 steps=3", done_err1, done_steps1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done_valid1 !== 1'b0)
            $display("FAIL b2b_pulse_width got dv=%b want 0", done_valid1);
        else n_pass++;
        @(negedge clk);   // FSM free-runs 1 -> 2
    endtask

    // Target equal to where the FSM lands, then an out-of-range target.
    task automatic test_zero_and_invalid();
        cmd_valid1 = 1'b1; cmd_target1 = 3'd2;
        @(negedge clk);
        n_total++;
        if ({done_valid1, done_err1, done_steps1, a1, cmd_ready1, state_obs1} !== {2'b10, 3'd0, 2'b01, 3'd2})
            $display("FAIL zero_step got dv=%b err=%b steps=%0d a=%b rdy=%b s=%0d want 1 0 0 0 1 2",
                     done_valid1, done_err1, done_steps1, a1, cmd_ready1, state_obs1);
        else n_pass++;
        cmd_target1 = 3'd6;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        n_total++;
        if ({done_valid1, done_err1, done_steps1, a1, cmd_ready1} !== {2'b11, 3'd0, 2'b01})
            $display("FAIL invalid_target got dv=%b err=%b steps=%0d a=%b rdy=%b want 1 1 0 0 1",
                     done_valid1, done_err1, done_steps1, a1, cmd_ready1);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done_valid1, a1, state_obs1} !== {2'b00, 3'd2})
            $display("FAIL invalid_after got dv=%b a=%b s=%0d want 0 0 2", done_valid1, a1, state_obs1);
        else n_pass++;
    endtask

    // MAX_STEPS=2 instance: 2 -> 1 needs 3 steps, so it times out after 2.
    task automatic test_timeout();
        logic [5:0] exp_v [3];
        exp_v = '{{1'b1, 3'd2, 2'b00}, {1'b0, 3'd3, 2'b00}, {1'b0, 3'd0, 2'b11}};
        cmd_valid2 = 1'b1; cmd_target2 = 3'd1;
        @(negedge clk);
        cmd_valid2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if ({a2, state_obs2, done_valid2, cmd_ready2} !== exp_v[k])
                $display("FAIL timeout cyc=%0d got {a,s,dv,rdy}=%b want %b", k,
                         {a2, state_obs2, done_valid2, cmd_ready2}, exp_v[k]);
            else n_pass++;
            if (k < 2) @(negedge clk);
        end
        n_total++;
        if ({done_err2, done_steps2} !== {1'b1, 3'd2})
            $display("FAIL timeout_err got err=%b steps=%0d want err=1 steps=2", done_err2, done_steps2);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({done_valid2, mismatch2} !== 2'b00)
            $display("FAIL timeout_after got dv=%b mm=%b want 0 0", done_valid2, mismatch2);
        else n_pass++;
    endtask

    // One-cycle corruption of dut2's observed state sets a sticky flag.
    task automatic test_mismatch();
        corrupt2 = 1'b1;
        @(negedge clk);
        corrupt2 = 1'b0;
        n_total++;
        if ({mismatch2, mismatch1} !== 2'b10)
            $display("FAIL mismatch_set got mm2=%b mm1=%b want mm2=1 mm1=0", mismatch2, mismatch1);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (mismatch2 !== 1'b1)
                $display("FAIL mismatch_sticky cyc=%0d got %b want 1", i, mismatch2);
            else n_pass++;
        end
    endtask

    // Reset during DRIVE aborts silently and both sides restart at 0.
    task automatic test_reset_mid_drive();
        logic [2:0] exp_s [3];
        exp_s = '{3'd1, 3'd2, 3'd2};
        cmd_valid1 = 1'b1; cmd_target1 = 3'd4;
        @(negedge clk);
        cmd_valid1 = 1'b0;
        @(negedge clk);
        n_total++;
        if ({a1, cmd_ready1, state_obs1} !== {2'b00, 3'd3})
            $display("FAIL pre_abort got a=%b rdy=%b s=%0d want 0 0 3", a1, cmd_ready1, state_obs1);
        else n_pass++;
        reset_l = 1'b0;
        #1;
        n_total++;
        if ({a1, cmd_ready1, done_valid1, mismatch2, state_obs1} !== {4'b0100, 3'd0})
            $display("FAIL async_abort got a=%b rdy=%b dv=%b mm2=%b s=%0d want 0 1 0 0 0",
                     a1, cmd_ready1, done_valid1, mismatch2, state_obs1);
        else n_pass++;
        @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({done_valid1, mismatch1, a1, state_obs1} !== {3'b000, exp_s[i]})
                $display("FAIL post_abort cyc=%0d got dv=%b mm=%b a=%b s=%0d want 0 0 0 %0d",
                         i, done_valid1, mismatch1, a1, state_obs1, exp_s[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset_l     = 1'b0;
        cmd_valid1  = 1'b0;
        cmd_valid2  = 1'b0;
        cmd_target1 = 3'd0;
        cmd_target2 = 3'd0;
        corrupt2    = 1'b0;
        test_reset();
        test_path_2_to_4();
        test_back_to_back();
        test_zero_and_invalid();
        test_timeout();
        test_mismatch();
        test_reset_mid_drive();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsm_path_driver.md
Name: fsm_path_driver

Overview:
- Initiator side of the single-bit `a` interface used by the 5-state control FSM (state codes 0..4).
- Accepts a target-state command, then drives `a` cycle by cycle along the shortest path until the FSM reaches that state, and reports completion.
- Keeps a shadow copy of the FSM state and checks it against the FSM's actual state output.
- Sits beside the FSM on the same clock and reset, and drives the FSM's `a` input directly.

Parameters:
- MAX_STEPS, 6: clocks allowed after command acceptance before the command is aborted with an error.

Ports:
- clk  in  1  clock, rising edge.
- reset_l  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low).
- cmd_valid  in  1  command request.
- cmd_target  in  3  requested target state.
- cmd_ready  out  1  high when a command can be accepted.
- a  out  1  registered drive into the FSM's `a` input.
- state_obs  in  3  the FSM's state output.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  qualifies done_valid: 1 = invalid target or timeout.
- done_steps  out  3  clocks from acceptance to completion, saturating at 7.
- mismatch  out  1  sticky: state_obs differed from the shadow state.

Behaviour:
- Reset (async, reset_l=0): ctl=IDLE, shadow=0, a=0, done_valid=0, done_err=0, done_steps=0, mismatch=0, step counter=0. The FSM shares this reset, so both sides start in state 0.
- Shadow model, updated every clock edge in every ctl state, using the current registered `a`:
  - 0: a ? 4 : 1
  - 1: a ? 3 : 2
  - 2: a ? 3 : 2
  - 3: 0
  - 4: a ? 0 : 4
  - 5..7: 0
- mismatch: set on any edge where state_obs != shadow (pre-update values compared). Cleared only by reset.
- next_a(s, t), the shortest-path table:
  - s==t gives 0.
  - s=0: 1 if t==4, else 0.
  - s=1: 0 if t==2, else 1.
  - s=2: 1.
  - s=3: 0.
  - s=4: 1.
  - Longest path is 3 steps (2->3->0->1, 2->3->0->4, 1->3->0->4).
- Control states IDLE and DRIVE. cmd_ready = (ctl==IDLE).
- IDLE: a <= 0. The FSM free-runs: from 0 it walks 0->1->2 and holds at 2; 4 holds; 3 goes to 0 then on to 2.
- Accept at an edge with cmd_valid && cmd_ready:
  - cmd_target > 4: stay IDLE; next cycle done_valid=1, done_err=1, done_steps=0; a stays 0.
  - Otherwise latch the target; step counter <= 1; s' = next-shadow.
    - If s' == target: done_valid=1, done_err=0, done_steps=0 next cycle; stay IDLE.
    - Else go to DRIVE with a <= next_a(s', target).
- DRIVE, each edge: s' = next-shadow.
  - If s' == target: done_valid=1, done_err=0, done_steps=counter, ctl<=IDLE, a<=0.
  - Else if counter == MAX_STEPS: done_valid=1, done_err=1, done_steps=counter (saturated), ctl<=IDLE, a<=0.
  - Else a <= next_a(s', target) and counter++.
- done_valid is asserted in the same cycle the FSM (and shadow) first shows the target state.
- done_valid is a single-cycle pulse. cmd_ready is already high in that cycle, so back-to-back commands are accepted.
- cmd_valid while busy is ignored (not accepted). cmd_target is sampled only on acceptance.
- mismatch does not abort DRIVE; completion is always judged on the shadow state.
- Reset asserted mid-DRIVE: immediate return to the reset values above. No done_valid is issued for the aborted command.

Test Plan:
- Reset, idle 4 clocks -> a=0 throughout; state_obs and shadow go 0,1,2,2; cmd_ready=1; mismatch=0.
- From idle at state 2, command target 4 -> a driven 1,0,1 over 3 cycles; FSM goes 3,0,4; done_valid with done_steps=3, done_err=0; a=0 afterwards, FSM holds at 4.
- At state 4, command target 1 -> a=1 then a=0; FSM goes 0,1; done_steps=2. Then command target 1 at state 1 -> FSM moves 1->2, and the driver walks 2->3->0->1 with done_steps=3.
- At state 2, command target 2 -> done_valid one cycle after acceptance with done_steps=0. Command target 6 -> done_err=1, done_steps=0, a stays 0.
- MAX_STEPS=2 override, state 2, target 1 -> done_err=1 after 2 steps, ctl returns to IDLE. Force state_obs != shadow for one cycle -> mismatch=1 and stays 1 until reset.
- Assert reset_l low in the middle of DRIVE -> a=0, cmd_ready=1, no done_valid; shadow=0 after release.
